// File: rtl/ysyx_22041211_ifu_axi_pkg.sv
// Shared encodings for the instruction-fetch unit: FSM states and AXI response codes.
package ysyx_22041211_ifu_axi_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_OUT  = 2'd3
    } ifu_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic resp_is_fault(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/ysyx_22041211_ifu_axi.sv
// IFU: one AXI-lite read per PC, handing {inst, pc} to decode with flush-safe dropping.
// Optional IFU_ACCESS_FAULT_EN adds inst_fault_o from a non-OKAY read response.
module ysyx_22041211_ifu_axi
    import ysyx_22041211_ifu_axi_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic                pc_valid_i,
    output logic                pc_ready_o,
    input  logic                flush_i,
    output logic [ADDR_LEN-1:0] inst_addr_r_addr_o,
    output logic                inst_addr_r_valid_o,
    input  logic                inst_addr_r_ready_i,
    input  logic [DATA_LEN-1:0] inst_r_data_i,
    input  logic [1:0]          inst_r_resp_i,
    input  logic                inst_r_valid_i,
    output logic                inst_r_ready_o,
    output logic [DATA_LEN-1:0] inst_o,
    output logic [ADDR_LEN-1:0] inst_pc_o,
    output logic                inst_valid_o,
`ifdef IFU_ACCESS_FAULT_EN
    output logic                inst_fault_o,
`endif
    input  logic                inst_ready_i
);

    ifu_state_e          state_q;
    logic                drop_q;
    logic [ADDR_LEN-1:0] pc_q;
    logic [DATA_LEN-1:0] inst_q;
`ifdef IFU_ACCESS_FAULT_EN
    logic                fault_q;
`else
    logic                unused_resp;
    assign unused_resp = ^inst_r_resp_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            drop_q  <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
`ifdef IFU_ACCESS_FAULT_EN
            fault_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (pc_valid_i) begin
                        pc_q    <= pc_i;
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    // AR stays up until accepted; a flush only marks the data stale
                    if (flush_i) drop_q <= 1'b1;
                    if (inst_addr_r_ready_i) state_q <= S_DATA;
                end
                S_DATA: begin
                    if (inst_r_valid_i) begin
                        drop_q <= 1'b0;
`ifdef IFU_ACCESS_FAULT_EN
                        fault_q <= resp_is_fault(inst_r_resp_i);
`endif
                        if (drop_q || flush_i) begin
                            state_q <= S_IDLE;
                        end else begin
                            inst_q  <= inst_r_data_i;
                            state_q <= S_OUT;
                        end
                    end else if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (flush_i || inst_ready_i) state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pc_ready_o          = (state_q == S_IDLE);
    assign inst_addr_r_valid_o = (state_q == S_ADDR);
    assign inst_addr_r_addr_o  = pc_q;
    assign inst_r_ready_o      = (state_q == S_DATA);
    assign inst_valid_o        = (state_q == S_OUT);
    assign inst_o              = inst_q;
    assign inst_pc_o           = pc_q;
`ifdef IFU_ACCESS_FAULT_EN
    assign inst_fault_o        = fault_q & (state_q == S_OUT);
`endif

endmodule

// File: tb/tb_ysyx_22041211_ifu_axi.sv
// Self-checking bench for ysyx_22041211_ifu_axi: directed scenarios plus random traffic.
// Reference: transaction-level rule "an accepted PC is delivered unless flushed later".
module tb_ysyx_22041211_ifu_axi;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic [31:0] inst_addr_r_addr_o;
    logic        inst_addr_r_valid_o;
    logic        inst_addr_r_ready_i;
    logic [31:0] inst_r_data_i;
    logic [1:0]  inst_r_resp_i;
    logic        inst_r_valid_i;
    logic        inst_r_ready_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
`ifdef IFU_ACCESS_FAULT_EN
    logic        inst_fault_o;
`endif

    always #5 clk = ~clk;

    ysyx_22041211_ifu_axi dut (
        .clk                (clk),
        .rst                (rst),
        .pc_i               (pc_i),
        .pc_valid_i         (pc_valid_i),
        .pc_ready_o         (pc_ready_o),
        .flush_i            (flush_i),
        .inst_addr_r_addr_o (inst_addr_r_addr_o),
        .inst_addr_r_valid_o(inst_addr_r_valid_o),
        .inst_addr_r_ready_i(inst_addr_r_ready_i),
        .inst_r_data_i      (inst_r_data_i),
        .inst_r_resp_i      (inst_r_resp_i),
        .inst_r_valid_i     (inst_r_valid_i),
        .inst_r_ready_o     (inst_r_ready_o),
        .inst_o             (inst_o),
        .inst_pc_o          (inst_pc_o),
        .inst_valid_o       (inst_valid_o),
`ifdef IFU_ACCESS_FAULT_EN
        .inst_fault_o       (inst_fault_o),
`endif
        .inst_ready_i       (inst_ready_i)
    );

    int total = 0;
    int bad   = 0;

    // CPU-side stimulus for the coming edge
    logic        rst_v = 1'b1;
    logic        pv    = 1'b0;
    logic [31:0] pc_v  = '0;
    logic        rdy   = 1'b0;
    logic        fl    = 1'b0;

    // slave configuration and state
    bit          rand_mode = 1'b0;
    int          ar_wait   = 0;
    int          r_wait    = 0;
    logic [1:0]  resp_cfg  = 2'b00;
    bit          s_pending = 1'b0;
    logic [31:0] s_addr    = '0;
    int          s_acnt    = 0;
    int          s_rcnt    = 0;
    int          s_rwait   = 0;
    logic [1:0]  s_resp    = 2'b00;
    logic [1:0]  s_last_resp = 2'b00;
    int          n_ar      = 0;

    // reference model
    bit          m_live  = 1'b0;
    logic [31:0] m_pc    = '0;
    int          n_deliv = 0;

    // outputs sampled at the negedge before the coming edge
    logic        o_pc_ready, o_ar_valid, o_r_ready, o_inst_valid, o_fault;
    logic [31:0] o_ar_addr, o_inst, o_inst_pc;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0073;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic step();
        logic ar_rdy;
        logic r_vld;
        @(negedge clk);
        o_pc_ready   = pc_ready_o;
        o_ar_valid   = inst_addr_r_valid_o;
        o_ar_addr    = inst_addr_r_addr_o;
        o_r_ready    = inst_r_ready_o;
        o_inst_valid = inst_valid_o;
        o_inst       = inst_o;
        o_inst_pc    = inst_pc_o;
`ifdef IFU_ACCESS_FAULT_EN
        o_fault      = inst_fault_o;
`else
        o_fault      = 1'b0;
`endif
        rst          = rst_v;
        pc_valid_i   = pv;
        pc_i         = pc_v;
        inst_ready_i = rdy;
        flush_i      = fl;
        if (rst_v) begin
            inst_addr_r_ready_i = 1'b0;
            inst_r_valid_i      = 1'b0;
            inst_r_data_i       = '0;
            inst_r_resp_i       = 2'b00;
            s_pending = 1'b0;
            s_acnt    = 0;
            m_live    = 1'b0;
            return;
        end
        r_vld = 1'b0;
        if (s_pending) begin
            r_vld = (s_rcnt >= s_rwait);
            if (r_vld && o_r_ready) begin
                s_pending   = 1'b0;
                s_last_resp = s_resp;
            end else begin
                s_rcnt++;
            end
        end
        inst_r_valid_i = r_vld;
        inst_r_data_i  = r_vld ? mem(s_addr) : 32'hdead_beef;
        inst_r_resp_i  = r_vld ? s_resp : 2'b00;
        ar_rdy = 1'b0;
        if (o_ar_valid) begin
            total++;
            if (s_pending) begin
                bad++;
                $display("FAIL second_outstanding ar_valid=%0b pending=%0b", o_ar_valid, s_pending);
            end
            if (s_acnt == 0 && rand_mode) ar_wait = $urandom % 3;
            ar_rdy = (s_acnt >= ar_wait);
            if (ar_rdy) begin
                s_pending = 1'b1;
                s_addr    = o_ar_addr;
                s_rcnt    = 0;
                s_acnt    = 0;
                s_resp    = rand_mode ? 2'($urandom % 4) : resp_cfg;
                s_rwait   = rand_mode ? int'($urandom % 3) : r_wait;
                n_ar++;
            end else begin
                s_acnt++;
            end
            total++;
            if (o_ar_addr !== m_pc) begin
                bad++;
                $display("FAIL ar_addr got=%h exp=%h", o_ar_addr, m_pc);
            end
        end else begin
            s_acnt = 0;
        end
        inst_addr_r_ready_i = ar_rdy;
        if (o_inst_valid) begin
            total++;
            if (!m_live) begin
                bad++;
                $display("FAIL spurious_valid pc=%h", o_inst_pc);
            end else begin
                total++;
                if (o_inst !== mem(m_pc) || o_inst_pc !== m_pc) begin
                    bad++;
                    $display("FAIL deliver inst=%h pc=%h exp_inst=%h exp_pc=%h",
                             o_inst, o_inst_pc, mem(m_pc), m_pc);
                end
`ifdef IFU_ACCESS_FAULT_EN
                total++;
                if (o_fault !== (s_last_resp != 2'b00)) begin
                    bad++;
                    $display("FAIL fault_flag got=%0b exp=%0b", o_fault, s_last_resp != 2'b00);
                end
`endif
            end
        end else begin
            total++;
            if (o_fault !== 1'b0) begin
                bad++;
                $display("FAIL fault_idle got=%0b exp=0", o_fault);
            end
        end
        if (o_pc_ready) begin
            total++;
            if (m_live) begin
                bad++;
                $display("FAIL lost_fetch pc=%h pc_ready=%0b", m_pc, o_pc_ready);
            end
        end
        if (o_inst_valid && rdy && !fl && m_live) begin
            m_live = 1'b0;
            n_deliv++;
        end
        if (fl) m_live = 1'b0;
        if (o_pc_ready && pv) begin
            m_live = 1'b1;
            m_pc   = pc_v;
        end
    endtask

    task automatic issue(input logic [31:0] a);
        bit ok = 1'b0;
        pv   = 1'b1;
        pc_v = a;
        for (int i = 0; i < 60; i++) begin
            step();
            if (o_pc_ready) begin
                ok = 1'b1;
                break;
            end
        end
        pv = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL issue_timeout pc=%h pc_ready=%0b", a, o_pc_ready);
        end
    endtask

    task automatic wait_valid(output int t);
        t = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            t++;
            if (o_inst_valid) break;
        end
        total++;
        if (!o_inst_valid) begin
            bad++;
            $display("FAIL valid_timeout inst_valid=%0b", o_inst_valid);
        end
    endtask

    task automatic test_reset();
        rst_v = 1'b1;
        step();
        step();
        total++;
        if (o_pc_ready !== 1'b1 || o_ar_valid !== 1'b0 || o_r_ready !== 1'b0 ||
            o_inst_valid !== 1'b0 || o_fault !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl pcr=%0b arv=%0b rr=%0b iv=%0b f=%0b exp=1,0,0,0,0",
                     o_pc_ready, o_ar_valid, o_r_ready, o_inst_valid, o_fault);
        end
        total++;
        if (o_inst !== 32'h0 || o_inst_pc !== 32'h0 || o_ar_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_data inst=%h pc=%h ar=%h exp=0", o_inst, o_inst_pc, o_ar_addr);
        end
        rst_v = 1'b0;
    endtask

    task automatic test_zero_wait();
        ar_wait = 0;
        r_wait  = 0;
        rdy     = 1'b1;
        issue(32'h8000_0000);
        step();
        total++;
        if (o_ar_valid !== 1'b1 || o_ar_addr !== 32'h8000_0000) begin
            bad++;
            $display("FAIL zw_ar valid=%0b addr=%h exp=1 80000000", o_ar_valid, o_ar_addr);
        end
        step();
        total++;
        if (o_r_ready !== 1'b1) begin
            bad++;
            $display("FAIL zw_r ready=%0b exp=1", o_r_ready);
        end
        step();
        total++;
        if (o_inst_valid !== 1'b1 || o_inst !== 32'h0010_0073 || o_inst_pc !== 32'h8000_0000) begin
            bad++;
            $display("FAIL zw_out valid=%0b inst=%h pc=%h exp=1 00100073 80000000",
                     o_inst_valid, o_inst, o_inst_pc);
        end
        step();
        total++;
        if (o_pc_ready !== 1'b1 || o_inst_valid !== 1'b0) begin
            bad++;
            $display("FAIL zw_idle pc_ready=%0b valid=%0b exp=1 0", o_pc_ready, o_inst_valid);
        end
    endtask

    task automatic test_ar_wait();
        int cnt = 0;
        int t   = 0;
        bit moved = 1'b0;
        ar_wait = 3;
        rdy     = 1'b1;
        issue(32'h8000_0010);
        for (int i = 0; i < 40; i++) begin
            step();
            t++;
            if (o_ar_valid) begin
                cnt++;
                if (o_ar_addr !== 32'h8000_0010) moved = 1'b1;
            end
            if (o_inst_valid) break;
        end
        total++;
        if (cnt != 4 || moved) begin
            bad++;
            $display("FAIL arw_hold cycles=%0d moved=%0b exp=4 0", cnt, moved);
        end
        total++;
        if (t != 6) begin
            bad++;
            $display("FAIL arw_latency got=%0d exp=6", t);
        end
        ar_wait = 0;
        step();
    endtask

    task automatic test_out_stall();
        int t;
        int d0;
        logic [31:0] hi, hp;
        rdy = 1'b0;
        d0  = n_deliv;
        issue(32'h8000_0020);
        wait_valid(t);
        hi = o_inst;
        hp = o_inst_pc;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (o_inst_valid !== 1'b1 || o_inst !== hi || o_inst_pc !== hp || o_pc_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold valid=%0b inst=%h pc=%h pcr=%0b exp=1 %h %h 0",
                         o_inst_valid, o_inst, o_inst_pc, o_pc_ready, hi, hp);
            end
        end
        rdy = 1'b1;
        step();
        step();
        total++;
        if (n_deliv - d0 != 1 || o_inst_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_count delivered=%0d valid=%0b exp=1 0", n_deliv - d0, o_inst_valid);
        end
    endtask

    task automatic test_flush_addr();
        int d0 = n_deliv;
        int a0 = n_ar;
        int t;
        bit seen = 1'b0;
        ar_wait = 2;
        rdy     = 1'b1;
        issue(32'h8000_0004);
        fl = 1'b1;
        step();
        fl = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_inst_valid) seen = 1'b1;
        end
        total++;
        if (seen || n_deliv != d0) begin
            bad++;
            $display("FAIL flush_addr_deliver seen=%0b delivered=%0d exp=0 0", seen, n_deliv - d0);
        end
        total++;
        if (n_ar - a0 != 1 || o_pc_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_addr_bus ar_done=%0d pcr=%0b exp=1 1", n_ar - a0, o_pc_ready);
        end
        ar_wait = 0;
        issue(32'h8000_0100);
        wait_valid(t);
        total++;
        if (o_inst !== mem(32'h8000_0100) || o_inst_pc !== 32'h8000_0100) begin
            bad++;
            $display("FAIL flush_addr_next inst=%h pc=%h exp=%h 80000100",
                     o_inst, o_inst_pc, mem(32'h8000_0100));
        end
        step();
    endtask

    task automatic test_flush_out();
        int t;
        int d0;
        rdy = 1'b0;
        d0  = n_deliv;
        issue(32'h8000_0040);
        wait_valid(t);
        rdy = 1'b1;
        fl  = 1'b1;
        step();
        fl  = 1'b0;
        step();
        total++;
        if (o_inst_valid !== 1'b0 || o_pc_ready !== 1'b1 || n_deliv != d0) begin
            bad++;
            $display("FAIL flush_out valid=%0b pcr=%0b delivered=%0d exp=0 1 0",
                     o_inst_valid, o_pc_ready, n_deliv - d0);
        end
    endtask

    task automatic test_reset_mid();
        rdy     = 1'b1;
        ar_wait = 5;
        issue(32'h8000_0200);
        step();
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        ar_wait = 0;
        step();
        total++;
        if (o_pc_ready !== 1'b1 || o_ar_valid !== 1'b0 || o_inst_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid pcr=%0b arv=%0b iv=%0b exp=1 0 0",
                     o_pc_ready, o_ar_valid, o_inst_valid);
        end
    endtask

`ifdef IFU_ACCESS_FAULT_EN
    task automatic test_fault();
        int t;
        rdy      = 1'b1;
        resp_cfg = 2'b10;
        issue(32'h8000_0080);
        wait_valid(t);
        total++;
        if (o_fault !== 1'b1) begin
            bad++;
            $display("FAIL fault_slverr got=%0b exp=1", o_fault);
        end
        step();
        resp_cfg = 2'b00;
        issue(32'h8000_0084);
        wait_valid(t);
        total++;
        if (o_fault !== 1'b0) begin
            bad++;
            $display("FAIL fault_okay got=%0b exp=0", o_fault);
        end
        step();
    endtask
`endif

    task automatic test_random();
        int d0 = n_deliv;
        rand_mode = 1'b1;
        for (int i = 0; i < 800; i++) begin
            pv   = ($urandom % 2) == 0;
            pc_v = {$urandom, 2'b00} >> 2 << 2;
            rdy  = ($urandom % 4) != 0;
            fl   = ($urandom % 10) == 0;
            step();
        end
        pv  = 1'b0;
        fl  = 1'b0;
        rdy = 1'b1;
        for (int i = 0; i < 20; i++) step();
        rand_mode = 1'b0;
        total++;
        if (n_deliv - d0 < 20 || o_pc_ready !== 1'b1) begin
            bad++;
            $display("FAIL random_progress delivered=%0d pcr=%0b exp>=20 1", n_deliv - d0, o_pc_ready);
        end
    endtask

    initial begin
        rst                 = 1'b1;
        pc_i                = '0;
        pc_valid_i          = 1'b0;
        flush_i             = 1'b0;
        inst_ready_i        = 1'b0;
        inst_addr_r_ready_i = 1'b0;
        inst_r_valid_i      = 1'b0;
        inst_r_data_i       = '0;
        inst_r_resp_i       = 2'b00;
        test_reset();
        test_zero_wait();
        test_ar_wait();
        test_out_stall();
        test_flush_addr();
        test_flush_out();
        test_reset_mid();
`ifdef IFU_ACCESS_FAULT_EN
        test_fault();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
